ysyx_25040129_ifu: RTL and testbench

Instruction fetch unit: owns the PC, issues one instruction-memory read at a time, and presents each fetched `{pc, inst}` pair on a valid/ready output. The output feeds the IF/ID pipeline register directly.

A redirect (branch, jump or trap target from later stages) replaces the PC immediately. It also discards any in-flight or held fetch. The redirect event is the same one that drives the pipeline register's flush.

---
 rtl/ysyx_25040129_ifu.sv | 117 +++++++++++
 tb/tb_ysyx_25040129_ifu.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch: owns the PC, keeps at most one imem read in flight, presents {pc, inst} downstream.
// Latency: first request 1 cycle after reset release; best case 3 cycles/instruction (REQ -> WAIT -> HOLD).
// Backpressure: request held until imem_req_ready, pair held until out_ready; a redirect masks both valids.
module ysyx_25040129_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [ADDR_WIDTH-1:0]      imem_req_addr,
    input  logic                       imem_resp_valid,
    input  logic [31:0]                imem_resp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH+31:0]     out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_nxt;
    logic [ADDR_WIDTH-1:0]   redirect_tgt;
    logic [31:0]             inst;
    logic [31:0]             inst_nxt;
    logic                    drop;
    logic                    drop_nxt;

    // Instructions are word aligned, so the low two target bits carry no information.
    assign redirect_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // A redirect in the same cycle kills both handshakes so nothing stale escapes.
    assign imem_req_valid = (state == REQ) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign out_valid      = (state == HOLD) && !redirect_valid;
    assign out_data       = {pc, inst};

    // State register; reset parks the FSM in IDLE so a late response is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: PC, captured instruction and the stale-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= RESET_PC;
            inst <= 32'h0;
            drop <= 1'b0;
        end else begin
            pc   <= pc_nxt;
            inst <= inst_nxt;
            drop <= drop_nxt;
        end
    end

    // Next-state and next-datapath decode; a redirect always wins the PC update.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        drop_nxt  = drop;
        if (redirect_valid) begin
            pc_nxt = redirect_tgt;
        end
        unique case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (!redirect_valid && imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        // Response belongs to a killed fetch: discard and refetch.
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        inst_nxt  = imem_resp_data;
                        state_nxt = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The memory still owes us a response; remember to throw it away.
                    drop_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = REQ;
                end else if (out_ready) begin
                    pc_nxt    = pc + ADDR_WIDTH'(4);
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
// Bench for the fetch unit: directed scenarios then randomized traffic, all against a transaction-level model.
// The model tracks the architectural fetch PC and which fetch (if any) is live, held, or stale.
// A simple memory model answers each accepted request after a programmable latency.
module tb_ysyx_25040129_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;

    ysyx_25040129_ifu #(
        .ADDR_WIDTH (32),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: next fetch PC plus the fate of the current fetch.
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_idle;
    bit          m_have;
    bit          m_out;
    bit          m_stale;

    // Memory model.
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_word = 32'h0;
    int          lat = 1;
    bit          ovr_en = 0;
    logic [31:0] ovr_word = 32'h0;

    // Per-cycle observations for the directed steps.
    bit          acc_now;
    bit          ov_now;
    bit          oh_now;
    logic [31:0] acc_addr;
    logic [63:0] ov_data;
    int          acc_cnt = 0;
    int          cyc_n = 0;
    logic [31:0] q_addr[$];
    int          q_cyc[$];
    logic [63:0] q_out[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_inst  = 32'h0;
        m_idle  = 1;
        m_have  = 0;
        m_out   = 0;
        m_stale = 0;
    endtask

    // One clock cycle: drive at posedge+1, sample/check mid-cycle, advance models, wait for next posedge+1.
    task automatic cyc(input logic rv, input logic [31:0] rpc, input logic ordy, input logic mrdy);
        logic exp_req;
        logic exp_ov;
        logic resp;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        out_ready       = ordy;
        resp            = mem_busy && (mem_cnt == 0);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word : $urandom;
        imem_req_ready  = mrdy && !mem_busy;
        #4;
        exp_req = !m_idle && !m_have && !m_out && !rv;
        exp_ov  = m_have && !rv;
        check("req_valid", imem_req_valid, exp_req);
        check("req_addr", imem_req_addr, m_pc);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) check("out_data", out_data, {m_pc, m_inst});
        acc_now  = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        ov_now   = out_valid;
        ov_data  = out_data;
        oh_now   = out_valid && out_ready;
        if (acc_now) begin
            acc_cnt++;
            q_addr.push_back(imem_req_addr);
            q_cyc.push_back(cyc_n);
        end
        if (oh_now) q_out.push_back(out_data);
        // Model: what the coming edge does to the fetch stream.
        m_idle = 0;
        if (rv) begin
            m_pc   = {rpc[31:2], 2'b00};
            m_have = 0;
        end
        if (m_out && resp) begin
            m_out = 0;
            if (!m_stale && !rv) begin
                m_have = 1;
                m_inst = imem_resp_data;
            end
            m_stale = 0;
        end else if (m_out && rv) begin
            m_stale = 1;
        end else if (exp_req && imem_req_ready) begin
            m_out   = 1;
            m_stale = 0;
        end else if (exp_ov && ordy) begin
            m_pc   = m_pc + 32'd4;
            m_have = 0;
        end
        // Memory: retire a response, start a new one on acceptance.
        if (resp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc_now) begin
            mem_busy = 1;
            mem_cnt  = lat - 1;
            mem_word = ovr_en ? ovr_word : word_of(imem_req_addr);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic wait_acc(input logic ordy, input string tag);
        int k;
        k = 0;
        do begin
            cyc(1'b0, 32'h0, ordy, 1'b1);
            k++;
        end while (!acc_now && k < 30);
        check({tag, "_acc_seen"}, acc_now, 1);
    endtask

    task automatic to_hold(input logic [31:0] w);
        int k;
        ovr_en   = 1;
        ovr_word = w;
        wait_acc(1'b1, "to_hold");
        ovr_en = 0;
        k = 0;
        do begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end while (!ov_now && k < 30);
        check("to_hold_ov", ov_now, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cyc_n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        bit          ov_seen;
        int          a0;
        logic [31:0] bp_addr;
        logic        rv;

        // Asynchronous reset before any clock edge.
        #1 rst = 1;
        #2;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, {RST_PC, 32'h0});
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        cyc_n = 0;

        // Streaming: always-ready memory, 1-cycle latency, always-ready consumer.
        lat = 1;
        q_addr.delete();
        q_cyc.delete();
        q_out.delete();
        repeat (9) cyc(1'b0, 32'h0, 1'b1, 1'b1);
        check("t1_nreq", q_addr.size(), 3);
        check("t1_addr0", q_addr[0], RST_PC);
        check("t1_addr1", q_addr[1], RST_PC + 32'd4);
        check("t1_addr2", q_addr[2], RST_PC + 32'd8);
        check("t1_cyc0", q_cyc[0], 1);
        check("t1_cyc1", q_cyc[1], 4);
        check("t1_cyc2", q_cyc[2], 7);
        check("t1_out0", q_out[0], {RST_PC, word_of(RST_PC)});
        check("t1_out1", q_out[1], {RST_PC + 32'd4, word_of(RST_PC + 32'd4)});

        // Back-pressure on a held NOP.
        to_hold(32'h0000_0013);
        bp_addr = acc_addr;
        a0 = acc_cnt;
        repeat (5) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1);
            check("bp_ov", ov_now, 1);
            check("bp_data", ov_data, {bp_addr, 32'h0000_0013});
        end
        check("bp_noreq", acc_cnt, a0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        check("bp_accept", oh_now, 1);
        wait_acc(1'b1, "bp");
        check("bp_next", acc_addr, bp_addr + 32'd4);

        // Redirect during WAIT; the stale response lands 3 cycles later.
        lat = 4;
        wait_acc(1'b1, "rw");
        cyc(1'b1, 32'h8000_1000, 1'b1, 1'b1);
        check("rw_ov_redirect", ov_now, 0);
        ov_seen = 0;
        k = 0;
        do begin
            cyc(1'b0, 32'h0, 1'b1, 1'b1);
            ov_seen |= ov_now;
            k++;
        end while (!acc_now && k < 30);
        check("rw_no_ov", ov_seen, 0);
        check("rw_next", acc_addr, 32'h8000_1000);

        // Redirect coincident with the response (low target bits must be dropped).
        lat = 1;
        wait_acc(1'b1, "rr");
        cyc(1'b1, 32'h8000_2002, 1'b1, 1'b1);
        check("rr_ov", ov_now, 0);
        wait_acc(1'b1, "rr");
        check("rr_next", acc_addr, 32'h8000_2000);

        // Redirect while holding a pair with out_ready high.
        to_hold(32'h1234_5678);
        cyc(1'b1, 32'h8000_3000, 1'b1, 1'b1);
        check("rh_ov", ov_now, 0);
        check("rh_no_handshake", oh_now, 0);
        wait_acc(1'b1, "rh");
        check("rh_next", acc_addr, 32'h8000_3000);

        // PC wrap-around.
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        wait_acc(1'b1, "wrap");
        check("wrap_first", acc_addr, 32'hFFFF_FFFC);
        wait_acc(1'b1, "wrap");
        check("wrap_next", acc_addr, 32'h0000_0000);

        // Asynchronous reset mid-WAIT with a late response.
        lat = 4;
        wait_acc(1'b1, "ar");
        #1 rst = 1;
        #1;
        check("ar_req_valid", imem_req_valid, 0);
        check("ar_req_addr", imem_req_addr, RST_PC);
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, {RST_PC, 32'h0});
        #1 rst = 0;
        model_reset();
        cyc_n = 0;
        ov_seen = 0;
        k = 0;
        do begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            ov_seen |= ov_now;
            k++;
        end while (mem_busy && k < 20);
        check("ar_late_resp_done", mem_busy, 0);
        check("ar_no_ov", ov_seen, 0);
        wait_acc(1'b1, "ar");
        check("ar_restart", acc_addr, RST_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            rv  = ($urandom_range(0, 9) == 0);
            cyc(rv, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        // Redirect arriving in the IDLE bubble still lands in the PC.
        do_reset();
        cyc(1'b1, 32'h8000_4000, 1'b1, 1'b0);
        k = 0;
        while (mem_busy && k < 10) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            k++;
        end
        wait_acc(1'b1, "idle_rd");
        check("idle_rd_addr", acc_addr, 32'h8000_4000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
